// File: rtl/mem_refill_controller.sv
// Cache-line refill controller: issues one memory request per miss and
// gathers NUM_BEATS beats into a block, optionally critical-word-first.
module mem_refill_controller #(
    parameter int ADDR_WIDTH     = 16,
    parameter int MEM_DATA_WIDTH = 40,
    parameter int NUM_BEATS      = 8,
    parameter int CWF_EN         = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_halt,
    input  logic [ADDR_WIDTH-1:0]               i_req_addr,
    input  logic                                i_req_valid,
    output logic                                o_req_ready,
    output logic [ADDR_WIDTH-1:0]               o_mem_req_addr,
    output logic                                o_mem_req_valid,
    input  logic                                i_mem_req_ready,
    input  logic [MEM_DATA_WIDTH-1:0]           i_mem_data,
    input  logic                                i_mem_data_valid,
    output logic                                o_mem_ready,
    output logic [NUM_BEATS*MEM_DATA_WIDTH-1:0] o_block_data,
    output logic                                o_block_data_valid,
    output logic [MEM_DATA_WIDTH-1:0]           o_crit_word,
    output logic                                o_crit_word_valid,
    output logic                                o_timeout_err,
    output logic                                o_busy
);

    localparam int OFS_W = $clog2(NUM_BEATS);
    localparam int STL_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [OFS_W:0]   LAST_BEAT = (OFS_W+1)'(NUM_BEATS - 1);
    localparam logic [STL_W-1:0] LAST_STALL = STL_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [OFS_W:0]          beat_cnt;
    logic [STL_W-1:0]        stall_cnt;
    logic                    crit_pend;
    logic                    to_pend;

    logic [OFS_W-1:0]        ofs;
    logic [OFS_W-1:0]        start;
    logic [OFS_W-1:0]        slot;
    logic [ADDR_WIDTH-1:0]   mem_addr;

    assign ofs   = addr_q[OFS_W-1:0];
    assign start = (CWF_EN != 0) ? ofs : '0;
    // Slot index wraps naturally in OFS_W bits.
    assign slot  = start + beat_cnt[OFS_W-1:0];

    assign mem_addr = (CWF_EN != 0) ? addr_q
                    : {addr_q[ADDR_WIDTH-1:OFS_W], {OFS_W{1'b0}}};

    assign o_req_ready        = (state == IDLE) & ~i_halt;
    assign o_mem_req_valid    = (state == REQ) & ~i_halt;
    assign o_mem_req_addr     = (state == REQ) ? mem_addr : '0;
    assign o_mem_ready        = (state == RECV) & ~i_halt;
    // Pulses are held pending across halt and released on the next live cycle.
    assign o_block_data_valid = (state == DONE) & ~i_halt;
    assign o_crit_word_valid  = crit_pend & ~i_halt;
    assign o_timeout_err      = to_pend & ~i_halt;
    assign o_busy             = (state != IDLE);

    // Refill FSM with beat gathering, stall watchdog and pending pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr_q       <= '0;
            beat_cnt     <= '0;
            stall_cnt    <= '0;
            crit_pend    <= 1'b0;
            to_pend      <= 1'b0;
            o_block_data <= '0;
            o_crit_word  <= '0;
        end else if (!i_halt) begin
            crit_pend <= 1'b0;
            to_pend   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        addr_q <= i_req_addr;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (i_mem_req_ready) begin
                        beat_cnt  <= '0;
                        stall_cnt <= '0;
                        state     <= RECV;
                    end
                end
                RECV: begin
                    if (i_mem_data_valid) begin
                        o_block_data[int'(slot)*MEM_DATA_WIDTH +: MEM_DATA_WIDTH]
                            <= i_mem_data;
                        if (slot == ofs) begin
                            o_crit_word <= i_mem_data;
                            crit_pend   <= 1'b1;
                        end
                        beat_cnt  <= beat_cnt + 1'b1;
                        stall_cnt <= '0;
                        if (beat_cnt == LAST_BEAT) begin
                            state <= DONE;
                        end
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                        if (stall_cnt == LAST_STALL) begin
                            to_pend <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
